// File: rtl/inv_subbytes_seq.sv
// ============================================================================
// Module      : inv_subbytes_seq
// Description : Sequential AES InvSubBytes engine. Runs LANES inverse S-box
//               lookups per cycle over the 16 state bytes, so one state takes
//               16/LANES passes. Valid/ready handshake on input and output.
//               Optional macro INV_SBOX_REGISTERED_EN registers the ROM
//               outputs. This adds a DRAIN state and one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NGROUPS = 16 / LANES;
    localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int GW      = 8 * LANES;
    localparam logic [CW-1:0] c_LAST = CW'(NGROUPS - 1);

    // FIPS-197 inverse S-box, entry 0 in the most significant byte
    localparam logic [2047:0] c_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return c_INV_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
            $error("inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Group 0 occupies the most significant GW bits, lane 0 the top byte of a group
    logic [0:NGROUPS-1][GW-1:0] r_work;
    logic [0:NGROUPS-1][GW-1:0] w_work_nxt;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_cnt_nxt;
    logic [GW-1:0]              w_lut;

    // One ROM per lane, looking up the group selected by the counter
    generate
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign w_lut[GW-1-8*l -: 8] = inv_sbox(r_work[r_cnt][GW-1-8*l -: 8]);
        end
    endgenerate

`ifdef INV_SBOX_REGISTERED_EN
    logic [GW-1:0] r_lut;
    logic [CW-1:0] r_wb_grp;
    logic          r_lut_vld;

    // Pipeline the lookup result and remember which group it belongs to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lut     <= '0;
            r_wb_grp  <= '0;
            r_lut_vld <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_lut     <= w_lut;
            r_wb_grp  <= r_cnt;
            r_lut_vld <= 1'b1;
        end else begin
            r_lut_vld <= 1'b0;
        end
    end
`endif

    // Next-state, counter and work-register update
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
`ifdef INV_SBOX_REGISTERED_EN
        // A lookup made on the previous edge lands one edge later
        if (r_lut_vld) begin
            w_work_nxt[r_wb_grp] = r_lut;
        end
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_work_nxt  = state_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
`ifndef INV_SBOX_REGISTERED_EN
                w_work_nxt[r_cnt] = w_lut;
`endif
                if (r_cnt == c_LAST) begin
`ifdef INV_SBOX_REGISTERED_EN
                    w_state_nxt = S_DRAIN;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counter and work register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_BUSY) || (r_state == S_DRAIN);
    // Only a finished state is exposed; partial results never reach the port
    assign state_out = (r_state == S_DONE) ? r_work : 128'h0;

endmodule

`default_nettype wire

// File: tb/tb_inv_subbytes_seq.sv
// ============================================================================
// Module      : tb_inv_subbytes_seq
// Description : Self-checking bench for inv_subbytes_seq. Four instances
//               (LANES = 4, 1, 2, 16) share stimulus. The expected values come
//               from an inverse S-box derived from GF(2^8) inversion and the
//               AES affine map.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inv_subbytes_seq;

`ifdef INV_SBOX_REGISTERED_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam int NI = 4;
    localparam int c_LANES [NI] = '{4, 1, 2, 16};

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic [127:0]  state_in;
    logic [NI-1:0] in_ready;
    logic [NI-1:0] out_valid;
    logic [NI-1:0] busy;
    logic [127:0]  state_out [NI];

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   ref_inv [256];
    int           lat [NI];
    logic [127:0] res [NI];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            inv_subbytes_seq #(.LANES(c_LANES[gi])) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid),
                .in_ready  (in_ready[gi]),
                .state_in  (state_in),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready),
                .state_out (state_out[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    task automatic build_ref();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            ref_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] o;
        for (int b = 0; b < 16; b++) begin
            o[127-8*b -: 8] = ref_inv[s[127-8*b -: 8]];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_all_idle();
        int cyc;
        cyc = 0;
        while (in_ready !== {NI{1'b1}} && cyc < 64) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    // One transaction with out_ready held high; records latency and result per instance
    task automatic run_one(input logic [127:0] s);
        bit seen [NI];
        int nseen;
        int cyc;
        wait_all_idle();
        for (int i = 0; i < NI; i++) begin
            seen[i] = 1'b0;
            lat[i]  = -1;
            res[i]  = 'x;
        end
        out_ready = 1'b1;
        state_in  = s;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        state_in = rand128();
        nseen = 0;
        cyc   = 0;
        while (nseen < NI && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!seen[i] && out_valid[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = cyc;
                    res[i]  = state_out[i];
                    nseen++;
                end
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        state_in = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_total++;
            if ({in_ready[i], out_valid[i], busy[i]} !== 3'b100 || state_out[i] !== 128'h0) begin
                $display("FAIL reset_state[%0d]: got rdy/vld/busy=%b%b%b out=%h, want 100 out=0",
                         i, in_ready[i], out_valid[i], busy[i], state_out[i]);
            end else n_pass++;
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        wait_all_idle();
        out_ready = 1'b1;
        state_in  = {16{8'h63}};
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_total++;
        if ({busy[0], in_ready[0]} !== 2'b10) begin
            $display("FAIL busy_after_capture: got busy/rdy=%b%b, want 10", busy[0], in_ready[0]);
        end else n_pass++;
        cyc = 0;
        while (out_valid[0] !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_total++;
        if (cyc != 4 + EXTRA) begin
            $display("FAIL latency_lanes4: got %0d, want %0d", cyc, 4 + EXTRA);
        end else n_pass++;
        n_total++;
        if (state_out[0] !== 128'h0) begin
            $display("FAIL all63_result: got %h, want 0", state_out[0]);
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({in_ready[0], out_valid[0]} !== 2'b10) begin
            $display("FAIL ready_after_handshake: got rdy/vld=%b%b, want 10", in_ready[0], out_valid[0]);
        end else n_pass++;
    endtask

    task automatic test_patterns();
        logic [127:0] bo_in;
        logic [127:0] bo_exp;
        run_one(128'h0);
        n_total++;
        if (res[0] !== {16{8'h52}} || lat[0] != 4 + EXTRA) begin
            $display("FAIL zero_state: got %h lat %0d, want %h lat %0d", res[0], lat[0], {16{8'h52}}, 4 + EXTRA);
        end else n_pass++;
        run_one({16{8'h16}});
        n_total++;
        if (res[0] !== {16{8'hff}}) begin
            $display("FAIL all16_state: got %h, want %h", res[0], {16{8'hff}});
        end else n_pass++;
        bo_in  = 128'h637C_0016_ED00_0000_0000_0000_0000_0000;
        bo_exp = 128'h0001_52FF_5352_5252_5252_5252_5252_5252;
        run_one(bo_in);
        for (int i = 0; i < NI; i++) begin
            n_total++;
            if (res[i] !== bo_exp) begin
                $display("FAIL byte_order[%0d]: got %h, want %h", i, res[i], bo_exp);
            end else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] s;
        logic [127:0] exp;
        int cyc;
        wait_all_idle();
        s   = rand128();
        exp = ref_state(s);
        out_ready = 1'b0;
        state_in  = s;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (out_valid !== {NI{1'b1}} && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        n_total++;
        if (out_valid !== {NI{1'b1}}) begin
            $display("FAIL stall_reach_done: got out_valid=%b, want all ones", out_valid);
        end else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                in_valid = 1'b1;
                state_in = ~s;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_total++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== exp) begin
                $display("FAIL stall_hold cycle %0d: got vld=%b rdy=%b out=%h, want vld=1 rdy=0 out=%h",
                         k, out_valid[0], in_ready[0], state_out[0], exp);
            end else n_pass++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({out_valid[0], in_ready[0]} !== 2'b01) begin
            $display("FAIL stall_release: got vld/rdy=%b%b, want 01", out_valid[0], in_ready[0]);
        end else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({busy[0], in_ready[0]} !== 2'b01) begin
            $display("FAIL ignored_pulse: got busy/rdy=%b%b, want 01", busy[0], in_ready[0]);
        end else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [127:0] s;
        logic [127:0] exp;
        bit seen_valid;
        wait_all_idle();
        out_ready = 1'b1;
        state_in  = rand128();
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (in_ready !== {NI{1'b1}} || out_valid !== '0 || busy !== '0 || state_out[0] !== 128'h0) begin
            $display("FAIL midop_reset: got rdy=%b vld=%b busy=%b out0=%h, want 1111 0000 0000 0",
                     in_ready, out_valid, busy, state_out[0]);
        end else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        seen_valid = 1'b0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== '0) seen_valid = 1'b1;
        end
        n_total++;
        if (seen_valid) begin
            $display("FAIL aborted_output: got out_valid asserted after reset, want none");
        end else n_pass++;
        s   = rand128();
        exp = ref_state(s);
        run_one(s);
        n_total++;
        if (res[0] !== exp || lat[0] != 4 + EXTRA) begin
            $display("FAIL after_reset: got %h lat %0d, want %h lat %0d", res[0], lat[0], exp, 4 + EXTRA);
        end else n_pass++;
    endtask

    task automatic test_random_sweep();
        logic [127:0] s;
        logic [127:0] exp;
        int want_lat;
        for (int t = 0; t < 256; t++) begin
            s   = rand128();
            exp = ref_state(s);
            run_one(s);
            for (int i = 0; i < NI; i++) begin
                want_lat = 16 / c_LANES[i] + EXTRA;
                n_total++;
                if (res[i] !== exp) begin
                    $display("FAIL sweep_data lanes=%0d t=%0d: got %h, want %h", c_LANES[i], t, res[i], exp);
                end else n_pass++;
                n_total++;
                if (lat[i] != want_lat) begin
                    $display("FAIL sweep_latency lanes=%0d t=%0d: got %0d, want %0d", c_LANES[i], t, lat[i], want_lat);
                end else n_pass++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_ref();
        test_reset();
        test_basic();
        test_patterns();
        test_backpressure();
        test_reset_midop();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
